seq_mul4: RTL and testbench



---
 rtl/seq_mul4.sv | 105 ++++++++++
 tb/tb_seq_mul4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul4.sv
// Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, with start/busy/done.
// Optional macro SEQ_MUL4_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mul4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic               c;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] result;
    logic [CNT_W-1:0]   cnt_inc;
    logic               finish;

`ifdef SEQ_MUL4_EARLY_TERM_EN
    logic [WIDTH-1:0]   rest;
    logic [CNT_W-1:0]   k;
`endif

    // Partial-product adder {C,A} = A + M, then one-bit right shift of {C,A,Q}.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
        sum     = {c, acc} + (q[0] ? {1'b0, m} : '0);
        shifted = {sum, q[WIDTH-1:1]};
        cnt_inc = cnt + 1'b1;
`ifdef SEQ_MUL4_EARLY_TERM_EN
        // Unexamined multiplier bits after this step are q[WIDTH-1-cnt:1].
        rest    = (q >> 1) & ({WIDTH{1'b1}} >> cnt_inc);
        k       = CNT_W'(WIDTH - 1) - cnt;
        finish  = (rest == '0);
        result  = shifted >> k;
`else
        finish  = (cnt == CNT_W'(WIDTH - 1));
        result  = shifted;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    c   <= 1'b0;
                    acc <= shifted[2*WIDTH-1:WIDTH];
                    q   <= shifted[WIDTH-1:0];
                    cnt <= cnt_inc;
                    if (finish) begin
                        product <= result;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul4.sv
// Scoreboard bench for seq_mul4: driver pushes a*b and expected latency, negedge monitor checks them.
module tb_seq_mul4;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_pass = 0;
    int             cyc = 0;
    int             run_cycles = 0;
    logic [2*W-1:0] last_prod = '0;

    seq_mul4 #(.WIDTH(W), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Run length: WIDTH cycles, or up to the highest set multiplier bit with early termination.
    function automatic int exp_lat(input logic [W-1:0] y);
        int l;
`ifdef SEQ_MUL4_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < W; i++) if (y[i]) l = i + 1;
`else
        l = W;
`endif
        return l;
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.prod = (2*W)'(int'(x) * int'(y));
        e.lat  = exp_lat(y);
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", busy, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check("done_timeout", done, 1);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_ready();
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(make_exp(x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every done must match the oldest expectation; product must hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cycles = 0;
            last_prod  = '0;
        end else begin
            if (busy) run_cycles++;
            if (done) begin
                check("busy_in_done", busy, 0);
                check("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", product, e.prod);
                    check("latency", run_cycles, e.lat);
                    last_prod = e.prod;
                end
                run_cycles = 0;
            end else begin
                check("product_hold", product, last_prod);
            end
        end
    end

    initial begin
        int t0, t1, span;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;

        issue(0, 0);
        drain();
        check("idle_busy", busy, 0);
        issue(15, 15);
        issue(3, 5);
        drain();

        // Exhaustive sweep with start held high through every DONE cycle.
        span = 0;
        t0 = 0;
        wait_ready();
        a = '0;
        b = '0;
        start = 1'b1;
        sb.push_back(make_exp(0, 0));
        for (int i = 1; i < N; i++) begin
            wait_done();
            if (i == 1) t0 = cyc;
            a = W'(i >> W);
            b = W'(i);
            sb.push_back(make_exp(W'(i >> W), W'(i)));
            span += exp_lat(W'(i)) + 1;
        end
        wait_done();
        t1 = cyc;
        start = 1'b0;
        check("sweep_span", t1 - t0, span);
        drain();

        // A start during RUN must not disturb the running operation.
        issue(9, 6);
        @(negedge clk);
        a = 1;
        b = 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();
        check("ignored_start_product", product, 54);

        // Asynchronous reset mid-run clears outputs at once.
        issue(7, 7);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_product", product, 0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_product", product, 0);

        issue(7, 1);
        issue(5, 4);
        drain();

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
